// File: rtl/fpu_pkg.sv
// fpu_pkg: shared IEEE-754 single-precision constants and field layout for the FPU blocks
package fpu_pkg;
  localparam int FLOAT_BIAS = 127;
  localparam int EXP_W = 8;
  localparam int MANT_W = 23;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [MANT_W-1:0] mant;
  } float_t;
endpackage

// File: rtl/lzc32.sv
// lzc32: combinational 32-bit leading-zero counter with all-zero flag
module lzc32 (
  input  logic [31:0] a,
  output logic [4:0]  cnt,
  output logic        zero
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 32; i++) cnt = a[i] ? 5'(31 - i) : cnt;
  end
  assign zero = ~|a;
endmodule

// File: rtl/itof_pipe.sv
// itof_pipe: 3-stage signed int32 to IEEE-754 single conversion with valid/ready handshakes
import fpu_pkg::*;
module itof_pipe #(
  parameter bit ROUND_TIES_AWAY = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready
);
  logic en;
  logic s1_v, s2_v, s3_v;
  logic s1_s, s2_s, s2_z;
  logic [31:0] s1_a;
  logic [30:0] s2_n;
  logic [7:0] s2_e;
  logic [4:0] lz;
  logic lz_zero;
  logic inc;
  logic [23:0] sum;
  float_t f;
  lzc32 u_lzc (.a(s1_a), .cnt(lz), .zero(lz_zero));
  assign en = !s3_v || out_ready;
  assign in_ready = en;
  assign out_valid = s3_v;
  // s2_n drops the normalized leading one, so bit 7 is guard and bits 6:0 form sticky
  assign inc = ROUND_TIES_AWAY ? s2_n[7] : s2_n[7] && ((|s2_n[6:0]) || s2_n[8]);
  assign sum = {1'b0, s2_n[30:8]} + {23'b0, inc};
  assign f = '{sign: s2_s, exp: s2_e + {7'b0, sum[23]}, mant: sum[23] ? '0 : sum[22:0]};
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      {s1_v, s2_v, s3_v} <= '0;
      s1_s <= 1'b0;
      s1_a <= '0;
      s2_s <= 1'b0;
      s2_z <= 1'b0;
      s2_n <= '0;
      s2_e <= '0;
      y <= '0;
    end else if (en) begin
      s1_v <= in_valid;
      s1_s <= x[31];
      s1_a <= x[31] ? ~x + 32'd1 : x;
      s2_v <= s1_v;
      s2_s <= s1_s;
      s2_z <= lz_zero;
      s2_n <= 31'(s1_a << lz);
      s2_e <= 8'(FLOAT_BIAS + 31) - {3'b0, lz};
      s3_v <= s2_v;
      y <= s2_z ? '0 : f;
    end
  end
endmodule
